// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch stage with PC, ROM request and DEPTH-entry fetch FIFO
//
// Purpose:
//    Owns the fetch PC, issues one read per cycle to a synchronous instruction
//    ROM (1-cycle read latency) and buffers the returned words, tagged with
//    their PC, in a DEPTH-entry FIFO.  Decode back-pressure (stall) holds the
//    FIFO head without losing or repeating instructions.  A taken branch/jump
//    (redirect_en) reloads the PC and discards everything buffered or in flight.
//
// Ports:
//    clk          in   clock, all state updates on the rising edge
//    reset        in   synchronous active-high reset, overrides every other input
//    stall        in   decode not ready, head entry is held
//    redirect_en  in   taken branch/jump this cycle
//    redirect_pc  in   redirect target PC
//    imem_req     out  ROM read issued this cycle
//    imem_addr    out  ROM address (current PC)
//    imem_rdata   in   ROM data, valid the cycle after imem_req
//    instr_valid  out  FIFO head valid
//    instr_out    out  FIFO head instruction
//    pc_out       out  PC of the FIFO head instruction
//    occupancy    out  FIFO fill level

module fetch_queue_unit #(
   parameter int          INST_W   = 24,
   parameter int          PC_W     = 16,
   parameter int          PC_STEP  = 4,
   parameter int          DEPTH    = 4,
   parameter int unsigned RESET_PC = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       stall,
   input  logic                       redirect_en,
   input  logic [PC_W-1:0]            redirect_pc,
   output logic                       imem_req,
   output logic [PC_W-1:0]            imem_addr,
   input  logic [INST_W-1:0]          imem_rdata,
   output logic                       instr_valid,
   output logic [INST_W-1:0]          instr_out,
   output logic [PC_W-1:0]            pc_out,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
   localparam logic [PC_W-1:0] PC_INC = PC_W'(PC_STEP);

   // fetch state
   logic [PC_W-1:0]   pc;
   logic [PC_W-1:0]   tag_pc;
   logic              inflight;

   // FIFO storage and bookkeeping
   logic [INST_W-1:0] mem_instr [DEPTH];
   logic [PC_W-1:0]   mem_pc    [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [CW-1:0]     count;

   logic              head_valid;
   logic              pop;
   logic              push;
   logic              issue;
   logic [CW:0]       demand;

   // Outputs are forced idle while reset is high, even in the first reset
   // cycle when the registers have not been cleared yet.
   assign head_valid = ~reset & (count != '0);

   assign pop  = head_valid & ~stall & ~redirect_en;
   assign push = ~reset & inflight & ~redirect_en;

   // Slots that will be committed after this cycle: current entries, minus the
   // one leaving, plus the response still on its way back from the ROM.  A new
   // request is only issued if its response is guaranteed a free slot, which
   // keeps count + inflight <= DEPTH and makes overflow impossible.
   // pop implies count >= 1, so the subtraction never wraps.
   assign demand = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
   assign issue  = ~reset & ~redirect_en & (demand < (CW+1)'(DEPTH));

   assign imem_req    = issue;
   assign imem_addr   = pc;
   assign instr_valid = head_valid;
   assign instr_out   = head_valid ? mem_instr[rd_ptr] : '0;
   assign pc_out      = head_valid ? mem_pc[rd_ptr]    : '0;
   assign occupancy   = reset ? '0 : count;

   // control state
   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= PC_RST;
         tag_pc   <= '0;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (redirect_en) begin
         // flush wins over any pop/push this cycle; the in-flight word is dropped
         pc       <= redirect_pc;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (issue) begin
            pc     <= pc + PC_INC;
            tag_pc <= pc;
         end
         inflight <= issue;

         // pointers wrap naturally because DEPTH is a power of two
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);

         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; push is already suppressed by reset and redirect
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= imem_rdata;
         mem_pc[wr_ptr]    <= tag_pc;
      end
   end

endmodule
